// File: rtl/seq_operand_forward_pipe_if.sv
// Purpose: READ/EXECUTE/WRITE operand-forwarding bundle between the pipeline control and the forward pipe.
// Latency: none; the interface carries wires only.
// Backpressure: o_stall_request flows back to the READ stage, and i_stall freezes the consumer.
interface seq_operand_forward_pipe_if #(
    parameter int DATA_SIZE      = 32,
    parameter int STALL_CNT_SIZE = 16
);
    logic                      i_stall;
    logic                      i_flush;
    logic                      i_read_valid;
    logic [DATA_SIZE-1:0]      i_operand1;
    logic [DATA_SIZE-1:0]      i_operand2;
    logic                      i_forward_operand1_execute;
    logic                      i_forward_operand2_execute;
    logic                      i_forward_operand1_write;
    logic                      i_forward_operand2_write;
    logic [DATA_SIZE-1:0]      i_result_execute;
    logic                      i_result_valid_execute;
    logic [DATA_SIZE-1:0]      o_operand1;
    logic [DATA_SIZE-1:0]      o_operand2;
    logic                      o_operand_valid;
    logic [DATA_SIZE-1:0]      o_result_write;
    logic                      o_result_write_valid;
    logic                      o_stall_request;
    logic                      o_hold_active;
    logic [STALL_CNT_SIZE-1:0] o_stall_cycles;

    // Pipeline control side: drives stage inputs and observes the pipe.
    modport master (
        output i_stall, i_flush, i_read_valid, i_operand1, i_operand2,
               i_forward_operand1_execute, i_forward_operand2_execute,
               i_forward_operand1_write, i_forward_operand2_write,
               i_result_execute, i_result_valid_execute,
        input  o_operand1, o_operand2, o_operand_valid, o_result_write,
               o_result_write_valid, o_stall_request, o_hold_active, o_stall_cycles
    );

    // Forward pipe side.
    modport slave (
        input  i_stall, i_flush, i_read_valid, i_operand1, i_operand2,
               i_forward_operand1_execute, i_forward_operand2_execute,
               i_forward_operand1_write, i_forward_operand2_write,
               i_result_execute, i_result_valid_execute,
        output o_operand1, o_operand2, o_operand_valid, o_result_write,
               o_result_write_valid, o_stall_request, o_hold_active, o_stall_cycles
    );
endinterface

// File: rtl/seq_operand_forward_pipe.sv
// Purpose: apply forward selects to the READ operands and register them into EXECUTE, and register the EXECUTE result into WRITE.
// Latency: one cycle for operands and one cycle for results; o_stall_request is combinational.
// Backpressure: a pending EXECUTE result holds EXECUTE and bubbles WRITE. i_stall freezes all state, and i_flush overrides i_stall.
module seq_operand_forward_pipe #(
    parameter int DATA_SIZE      = 32,
    parameter int STALL_CNT_SIZE = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    seq_operand_forward_pipe_if.slave   bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [STALL_CNT_SIZE-1:0] CNT_ONE = {{(STALL_CNT_SIZE-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_SIZE-1:0] CNT_MAX = {STALL_CNT_SIZE{1'b1}};

    logic [DATA_SIZE-1:0]      operand1_q, operand1_d;
    logic [DATA_SIZE-1:0]      operand2_q, operand2_d;
    logic                      operand_valid_q, operand_valid_d;
    logic [DATA_SIZE-1:0]      result_write_q, result_write_d;
    logic                      result_write_valid_q, result_write_valid_d;
    logic [0:0]                state_q, state_d;
    logic [STALL_CNT_SIZE-1:0] stall_cycles_q, stall_cycles_d;

    logic                      fwd1_exec, fwd2_exec, fwd1_write, fwd2_write;
    logic [DATA_SIZE-1:0]      sel_operand1, sel_operand2;
    logic                      hazard;

    // Gate the forward flags with READ validity, pick the operand sources, and detect a pending result.
    always_comb begin
        fwd1_exec  = bus.i_read_valid & bus.i_forward_operand1_execute;
        fwd2_exec  = bus.i_read_valid & bus.i_forward_operand2_execute;
        fwd1_write = bus.i_read_valid & bus.i_forward_operand1_write & result_write_valid_q;
        fwd2_write = bus.i_read_valid & bus.i_forward_operand2_write & result_write_valid_q;

        sel_operand1 = bus.i_operand1;
        if (fwd1_exec)       sel_operand1 = bus.i_result_execute;
        else if (fwd1_write) sel_operand1 = result_write_q;

        sel_operand2 = bus.i_operand2;
        if (fwd2_exec)       sel_operand2 = bus.i_result_execute;
        else if (fwd2_write) sel_operand2 = result_write_q;

        hazard = bus.i_read_valid & operand_valid_q & (fwd1_exec | fwd2_exec)
                 & ~bus.i_result_valid_execute;
    end

    // Compute the next pipeline register values in priority order: flush, freeze, hazard, then advance.
    always_comb begin
        operand1_d           = operand1_q;
        operand2_d           = operand2_q;
        operand_valid_d      = operand_valid_q;
        result_write_d       = result_write_q;
        result_write_valid_d = result_write_valid_q;
        if (bus.i_flush) begin
            operand_valid_d      = 1'b0;
            result_write_valid_d = 1'b0;
        end else if (bus.i_stall) begin
            operand_valid_d      = operand_valid_q;
        end else if (hazard) begin
            // The pending instruction stays in EXECUTE, and WRITE receives a bubble.
            result_write_valid_d = 1'b0;
        end else begin
            operand1_d           = sel_operand1;
            operand2_d           = sel_operand2;
            operand_valid_d      = bus.i_read_valid;
            result_write_d       = bus.i_result_execute;
            result_write_valid_d = operand_valid_q & bus.i_result_valid_execute;
        end
    end

    // Compute the RUN/HOLD next state and the saturating HOLD-cycle count.
    always_comb begin
        state_d        = state_q;
        stall_cycles_d = stall_cycles_q;
        if (bus.i_flush) begin
            state_d = ST_RUN;
        end else if (!bus.i_stall) begin
            case (state_q)
                ST_RUN:  if (hazard) state_d = ST_HOLD;
                ST_HOLD: if (bus.i_result_valid_execute) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
        // The count tracks HOLD residency, so a flush edge in HOLD still counts.
        if ((state_q == ST_HOLD) && !bus.i_stall && (stall_cycles_q != CNT_MAX))
            stall_cycles_d = stall_cycles_q + CNT_ONE;
    end

    // Update all state registers; reset forces RUN with every valid cleared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            operand1_q           <= '0;
            operand2_q           <= '0;
            operand_valid_q      <= 1'b0;
            result_write_q       <= '0;
            result_write_valid_q <= 1'b0;
            state_q              <= ST_RUN;
            stall_cycles_q       <= '0;
        end else begin
            operand1_q           <= operand1_d;
            operand2_q           <= operand2_d;
            operand_valid_q      <= operand_valid_d;
            result_write_q       <= result_write_d;
            result_write_valid_q <= result_write_valid_d;
            state_q              <= state_d;
            stall_cycles_q       <= stall_cycles_d;
        end
    end

    assign bus.o_operand1           = operand1_q;
    assign bus.o_operand2           = operand2_q;
    assign bus.o_operand_valid      = operand_valid_q;
    assign bus.o_result_write       = result_write_q;
    assign bus.o_result_write_valid = result_write_valid_q;
    assign bus.o_stall_request      = hazard & ~bus.i_flush;
    assign bus.o_hold_active        = (state_q == ST_HOLD);
    assign bus.o_stall_cycles       = stall_cycles_q;
endmodule

// File: doc/seq_operand_forward_pipe.md
# seq_operand_forward_pipe

Consumer side of the core's operand-forwarding path. It takes the four forward-select flags produced by the combinational data-dependency block and applies them to the READ-stage operands, selecting among the register-file value, the EXECUTE result and the WRITE-stage result. It registers the selected operands into the EXECUTE stage and registers the EXECUTE result into the WRITE stage. When an EXECUTE result is still pending and is needed, it raises a stall request and inserts bubbles.

## Interface
- DATA_SIZE, 32, operand/result width
- STALL_CNT_SIZE, 16, width of the saturating stall-cycle counter
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_stall  input  1  global freeze; all registers hold
- i_flush  input  1  kill in-flight READ/EXECUTE contents
- i_read_valid  input  1  READ stage holds a valid instruction
- i_operand1, i_operand2  input  DATA_SIZE  register-file read values
- i_forward_operand1_execute, i_forward_operand2_execute  input  1  source n matches the EXECUTE destination
- i_forward_operand1_write, i_forward_operand2_write  input  1  source n matches the WRITE destination
- i_result_execute  input  DATA_SIZE  EXECUTE-stage result (combinational)
- i_result_valid_execute  input  1  i_result_execute is final this cycle
- o_operand1, o_operand2  output  DATA_SIZE  registered EXECUTE operands
- o_operand_valid  output  1  EXECUTE stage holds a valid instruction
- o_result_write  output  DATA_SIZE  registered WRITE-stage result
- o_result_write_valid  output  1  o_result_write is a valid result
- o_stall_request  output  1  combinational; READ stage must hold
- o_hold_active  output  1  registered; FSM is in HOLD
- o_stall_cycles  output  STALL_CNT_SIZE  saturating count of HOLD cycles

## Operation
Operand selection, per operand n, combinational:
- Execute forwarding takes priority over write forwarding.
- If i_forward_operandn_execute is set, select i_result_execute.
- Otherwise, if i_forward_operandn_write is set and o_result_write_valid = 1, select o_result_write.
- Otherwise select i_operandn.
- When i_read_valid = 0, all forward flags are ignored.

Hazard:
- hazard = i_read_valid & o_operand_valid & (fwd1_exec | fwd2_exec) & ~i_result_valid_execute.
- o_stall_request = hazard & ~i_flush.

FSM states:
- RUN (reset state) and HOLD.
- RUN -> HOLD on hazard & ~i_stall & ~i_flush.
- HOLD -> RUN when i_result_valid_execute = 1 or i_flush = 1.
- All other cases keep the current state.
- o_hold_active = (state == HOLD).

Register update on each edge, highest priority first:
- Flush (i_flush = 1):
  - o_operand_valid <= 0 and o_result_write_valid <= 0.
  - Data registers hold.
  - State <= RUN.
  - i_flush overrides i_stall.
- Freeze (i_stall = 1): every register holds, including the FSM and the counter.
- Hazard:
  - The EXECUTE operand registers hold (the pending instruction stays in EXECUTE).
  - The WRITE stage takes a bubble: o_result_write_valid <= 0.
- Normal advance:
  - o_operandn <= selected value.
  - o_operand_valid <= i_read_valid.
  - o_result_write <= i_result_execute.
  - o_result_write_valid <= o_operand_valid & i_result_valid_execute.
  - If o_operand_valid = 1 and i_result_valid_execute = 0 with no hazard, the EXECUTE instruction still advances and its result is dropped as invalid. Upstream guarantees this does not occur for register-writing instructions.

Stall counter:
- Increments by 1 on every edge where the state is HOLD and i_stall = 0.
- Saturates at all-ones with no wrap.
- Cleared only by reset.

## Timing
- Reset (i_rst_n = 0, asynchronous) drives immediately:
  - o_operand1 = o_operand2 = 0, o_operand_valid = 0.
  - o_result_write = 0, o_result_write_valid = 0.
  - o_hold_active = 0, o_stall_cycles = 0, state RUN.
- Reset asserted mid-HOLD forces RUN with all valids 0. Release is synchronous to the next i_clk edge.
- Operand latency: READ to o_operandn is one cycle.
- Result latency: i_result_execute to o_result_write is one cycle.
- o_stall_request is combinational, same cycle as the hazard. It may be high in RUN during the cycle the hazard is detected.
- The hazard resolves in the first cycle i_result_valid_execute = 1:
  - o_stall_request drops in that cycle.
  - The forwarded i_result_execute is captured at that edge.
  - o_hold_active falls one cycle later.
- Simultaneous i_flush and hazard: the flush wins, o_stall_request = 0, and no transition to HOLD occurs.

## Test plan
- Reset mid-HOLD: assert i_rst_n = 0 while o_stall_cycles = 5 -> all outputs 0 immediately, state RUN.
- No forwarding: i_operand1 = 0x11, i_operand2 = 0x22, i_read_valid = 1 -> next cycle o_operand1 = 0x11, o_operand2 = 0x22, o_operand_valid = 1.
- Both write and execute forwards on operand 1:
  - Setup: o_result_write = 0xAA valid, i_result_execute = 0xBB valid, fwd1_exec = 1, fwd1_write = 1, fwd2_write = 1.
  - Expected: o_operand1 = 0xBB, o_operand2 = 0xAA.
- Pending result:
  - Stimulus: fwd2_exec = 1, i_result_valid_execute = 0 for 3 cycles, then i_result_valid_execute = 1 with i_result_execute = 0x5.
  - Expected: o_stall_request high for 3 cycles; o_result_write_valid shows 3 bubbles; o_operand2 = 0x5 after release; o_stall_cycles = 3.
- Stall vs flush:
  - i_stall = 1 during HOLD -> all registers and o_stall_cycles frozen.
  - i_stall = 1 together with i_flush = 1 -> both valids 0 next cycle and state RUN.
- Counter saturation: with STALL_CNT_SIZE = 4, stay in HOLD for 20 cycles -> o_stall_cycles = 15 with no wrap.
